// File: rtl/fpaddsub_round_arbiter.sv
// Two-requester arbiter (A/B) in front of one shared FP rounding stage with a one-deep output register.
// Define FPADDSUB_ROUND_ARB_FLAGS_EN to add sticky inexact/overflow flags (ClrFlags, FlagInexact, FlagOvf).
module fpaddsub_round_arbiter (
    input  logic        CLK,
    input  logic        RST,
    input  logic [1:0]  RoundMode,

    input  logic        ValidA,
    output logic        ReadyA,
    input  logic        SgnA,
    input  logic [8:0]  NormEA,
    input  logic [22:0] NormMA,
    input  logic        RA,
    input  logic        SA,

    input  logic        ValidB,
    output logic        ReadyB,
    input  logic        SgnB,
    input  logic [8:0]  NormEB,
    input  logic [22:0] NormMB,
    input  logic        RB,
    input  logic        SB,

    output logic        OutValid,
    input  logic        OutReady,
    output logic        OutSgn,
    output logic [22:0] OutM,
    output logic [8:0]  OutE,
    output logic        OutSrc,
    output logic        OutInexact
`ifdef FPADDSUB_ROUND_ARB_FLAGS_EN
    ,
    input  logic        ClrFlags,
    output logic        FlagInexact,
    output logic        FlagOvf
`endif
);

    localparam logic [1:0] MODE_RNE = 2'b00;
    localparam logic [1:0] MODE_RPI = 2'b01;
    localparam logic [1:0] MODE_RZ  = 2'b10;
    localparam logic [1:0] MODE_RMI = 2'b11;

    typedef enum logic {
        PREF_A = 1'b0,
        PREF_B = 1'b1
    } ptr_e;

    ptr_e ptr_q;
    ptr_e ptr_d;

    logic        slot_free;
    logic        grant_a;
    logic        grant_b;
    logic        xfer_a;
    logic        xfer_b;
    logic        xfer;

    logic        op_sgn;
    logic [8:0]  op_e;
    logic [22:0] op_m;
    logic        op_r;
    logic        op_s;

    logic        round_up;
    logic [23:0] m_inc;
    logic [22:0] rnd_m;
    logic [8:0]  rnd_e;
    logic        rnd_inexact;

    // The slot can take a new result when it is empty or being drained this cycle.
    assign slot_free = ~OutValid | OutReady;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q <= PREF_A;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Grants look only at the valids and the pointer; the pointer flips to the other side after a transfer.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        ptr_d   = ptr_q;
        case ({ValidA, ValidB})
            2'b10: grant_a = 1'b1;
            2'b01: grant_b = 1'b1;
            2'b11: begin
                if (ptr_q == PREF_A) begin
                    grant_a = 1'b1;
                end else begin
                    grant_b = 1'b1;
                end
            end
            default: ;
        endcase
        if (grant_a & slot_free & ~RST) begin
            ptr_d = PREF_B;
        end else if (grant_b & slot_free & ~RST) begin
            ptr_d = PREF_A;
        end
    end

    assign ReadyA = grant_a & slot_free & ~RST;
    assign ReadyB = grant_b & slot_free & ~RST;
    assign xfer_a = ValidA & ReadyA;
    assign xfer_b = ValidB & ReadyB;
    assign xfer   = xfer_a | xfer_b;

    always_comb begin
        op_sgn = SgnA;
        op_e   = NormEA;
        op_m   = NormMA;
        op_r   = RA;
        op_s   = SA;
        if (grant_b) begin
            op_sgn = SgnB;
            op_e   = NormEB;
            op_m   = NormMB;
            op_r   = RB;
            op_s   = SB;
        end
    end

    always_comb begin
        round_up = 1'b0;
        case (RoundMode)
            MODE_RNE: round_up = op_r & (op_s | op_m[0]);
            MODE_RPI: round_up = (op_r | op_s) & ~op_sgn;
            MODE_RZ:  round_up = 1'b0;
            MODE_RMI: round_up = (op_r | op_s) & op_sgn;
            default:  round_up = 1'b0;
        endcase
    end

    // A mantissa carry out bumps the exponent; the 9-bit exponent is allowed to wrap.
    assign m_inc       = {1'b0, op_m} + 24'd1;
    assign rnd_m       = round_up ? m_inc[22:0] : op_m;
    assign rnd_e       = op_e + {8'd0, round_up & m_inc[23]};
    assign rnd_inexact = op_r | op_s;

    // RoundMode is consumed here in the accept cycle, so the held result never sees later mode changes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            OutValid   <= 1'b0;
            OutSgn     <= 1'b0;
            OutM       <= 23'd0;
            OutE       <= 9'd0;
            OutSrc     <= 1'b0;
            OutInexact <= 1'b0;
        end else if (xfer) begin
            OutValid   <= 1'b1;
            OutSgn     <= op_sgn;
            OutM       <= rnd_m;
            OutE       <= rnd_e;
            OutSrc     <= xfer_b;
            OutInexact <= rnd_inexact;
        end else if (OutReady) begin
            OutValid   <= 1'b0;
        end
    end

`ifdef FPADDSUB_ROUND_ARB_FLAGS_EN
    // A set from this cycle's transfer wins over a simultaneous clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            FlagInexact <= 1'b0;
            FlagOvf     <= 1'b0;
        end else begin
            FlagInexact <= (FlagInexact & ~ClrFlags) | (xfer & rnd_inexact);
            FlagOvf     <= (FlagOvf & ~ClrFlags) | (xfer & (rnd_e >= 9'd255));
        end
    end
`endif

endmodule
